// File: rtl/array_feeder_if.sv
// Host/array-facing signal bundle for array_feeder.
// The slave modport is the feeder's view; the master modport is the host/array environment.
interface array_feeder_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [N*DW-1:0] wr_data;
    logic            go;
    logic            busy;
    logic            finished;
    logic            arr_start;
    logic            arr_ready;
    logic            arr_done;
    logic [N*DW-1:0] w_out;
    logic [N*DW-1:0] a_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, go, arr_ready, arr_done,
        input  busy, finished, arr_start, w_out, a_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, go, arr_ready, arr_done,
        output busy, finished, arr_start, w_out, a_out
    );
endinterface

// File: rtl/array_feeder.sv
// Weight/activation feeder for an NxN weight-stationary systolic array.
// Optional FEEDER_WR_LOCK_EN: host writes are ignored while a run is in progress.
module array_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    array_feeder_if.slave io_bus
);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = $clog2(3 * N);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOAD, S_COMP, S_WAIT, S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_nxt;
    logic [N*DW-1:0] r_w [N];
    logic [N*DW-1:0] r_a [N];
    logic            w_wr_ok;
    logic [AW-1:0]   w_load_idx;
    logic [AW-1:0]   w_a_idx;

`ifdef FEEDER_WR_LOCK_EN
    assign w_wr_ok = io_bus.wr_en && (r_state == S_IDLE);
`else
    assign w_wr_ok = io_bus.wr_en;
`endif

    // Host-written weight and activation buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                r_w[i] <= '0;
                r_a[i] <= '0;
            end
        end else if (w_wr_ok && (32'(io_bus.wr_addr) < N)) begin
            if (io_bus.wr_sel) r_a[io_bus.wr_addr] <= io_bus.wr_data;
            else               r_w[io_bus.wr_addr] <= io_bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        unique case (r_state)
            S_IDLE: if (io_bus.go) begin
                w_state_nxt = S_ARM;
                w_k_nxt     = '0;
            end
            S_ARM: if (io_bus.arr_ready) begin
                w_state_nxt = S_LOAD;
                w_k_nxt     = '0;
            end
            S_LOAD: begin
                if (r_k == KW'(N - 1)) begin
                    w_state_nxt = S_COMP;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            S_COMP: begin
                if (r_k == KW'(3 * N - 1)) begin
                    w_state_nxt = S_WAIT;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            S_WAIT: if (io_bus.arr_done) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Moore outputs; bottom weight row first, activations skewed by lane index
    always_comb begin
        io_bus.busy      = (r_state != S_IDLE);
        io_bus.finished  = (r_state == S_FIN);
        io_bus.arr_start = (r_state == S_ARM);
        io_bus.w_out     = '0;
        io_bus.a_out     = '0;
        w_load_idx       = AW'(N - 1) - r_k[AW-1:0];
        w_a_idx          = '0;
        if (r_state == S_LOAD) io_bus.w_out = r_w[w_load_idx];
        if (r_state == S_COMP) begin
            for (int i = 0; i < int'(N); i++) begin
                if ((r_k >= KW'(i)) && (r_k < KW'(i + int'(N)))) begin
                    w_a_idx = AW'(r_k - KW'(i));
                    io_bus.a_out[i*DW +: DW] = r_a[w_a_idx][i*DW +: DW];
                end
            end
        end
    end
endmodule
